ws_array_ctrl: RTL and testbench

Sequencer for the N x N weight-stationary systolic array. Streams one weight tile into the array through the top IO, drives load_weight, and then injects activation vectors through the left IO with per-row skew. It de-skews the bottom partial sums into one aligned result vector per input vector. It sits between the tile buffers (weight and activation streams) and the array instance.

---
 rtl/ws_array_ctrl_pkg.sv | 22 ++
 rtl/ws_array_ctrl_if.sv | 24 ++
 rtl/ws_skew_line.sv | 34 +++
 rtl/ws_array_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ws_array_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws_array_ctrl_pkg.sv
// Shared types and constants for the weight-stationary array sequencer.
package ws_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } ws_state_e;

    localparam int unsigned ACT_W = 8;

    typedef logic [ACT_W-1:0]   act_word_t;
    typedef logic [2*ACT_W-1:0] psum_word_t;

    // Acceptance-to-result latency: N skew, N array rows, 1 capture stage.
    function automatic int unsigned ws_latency(input int unsigned n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/ws_array_ctrl_if.sv
// Weight, activation and result streams between the tile buffers and the sequencer.
interface ws_array_ctrl_if #(
    parameter int D_W = 8,
    parameter int N   = 4
);
    logic                      w_valid;
    logic                      w_ready;
    logic [N-1:0][D_W-1:0]     w_row;
    logic                      act_valid;
    logic                      act_ready;
    logic [N-1:0][D_W-1:0]     act_vec;
    logic                      res_valid;
    logic [N-1:0][2*D_W-1:0]   res_vec;

    modport master (
        output w_valid, w_row, act_valid, act_vec,
        input  w_ready, act_ready, res_valid, res_vec
    );

    modport slave (
        input  w_valid, w_row, act_valid, act_vec,
        output w_ready, act_ready, res_valid, res_vec
    );
endinterface

// File: rtl/ws_skew_line.sv
// Register delay line of DEPTH stages; DEPTH=0 degenerates to a wire.
module ws_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_s;
        assign unused_s = clk ^ rst;
        assign dout     = din;
    end else begin : g_reg
        logic [DEPTH-1:0][W-1:0] pipe_r;

        // Shift din through DEPTH registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_r <= '0;
            end else begin
                pipe_r[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end

        assign dout = pipe_r[DEPTH-1];
    end

endmodule

// File: rtl/ws_array_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: weight load, skewed
// activation injection and result de-skew. Optional WS_PERF_CNT_EN adds perf counters.
module ws_array_ctrl
    import ws_ctrl_pkg::*;
#(
    parameter int D_W   = ACT_W,
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     skip_load,
    input  logic [CNT_W-1:0]         num_vec,
    output logic                     busy,
    output logic                     done,
    ws_array_ctrl_if.slave           bus,
    output logic                     load_weight,
    output logic [N-1:0][D_W-1:0]    arr_m0,
    output logic [N-1:0][D_W-1:0]    arr_m1,
    input  logic [N-1:0][2*D_W-1:0]  arr_m2
`ifdef WS_PERF_CNT_EN
    ,
    output logic [31:0]              perf_cycles,
    output logic [31:0]              perf_bubbles
`endif
);

    localparam int L  = ws_latency(N);
    localparam int RW = $clog2(N + 1);

    ws_state_e             state_r;
    logic [CNT_W-1:0]      num_vec_r;
    logic [CNT_W-1:0]      acc_cnt_r;
    logic [RW-1:0]         row_cnt_r;
    logic                  w_ready_r;
    logic                  act_ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic [L-1:0]          tag_r;
    logic [N-1:0][D_W-1:0] act_cap_r;
    logic                  w_acc_s;
    logic                  act_acc_s;

    assign w_acc_s   = bus.w_valid & w_ready_r;
    assign act_acc_s = bus.act_valid & act_ready_r;

    // Job sequencing: state, stream readies and job counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            num_vec_r   <= '0;
            acc_cnt_r   <= '0;
            row_cnt_r   <= '0;
            w_ready_r   <= 1'b0;
            act_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r    <= 1'b1;
                        num_vec_r <= num_vec;
                        acc_cnt_r <= '0;
                        row_cnt_r <= '0;
                        if (skip_load) begin
                            state_r     <= ST_COMPUTE;
                            act_ready_r <= (num_vec != '0);
                        end else begin
                            state_r   <= ST_LOAD;
                            w_ready_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_acc_s) begin
                        if (row_cnt_r == RW'(N - 1)) begin
                            w_ready_r <= 1'b0;
                            if (num_vec_r == '0) begin
                                state_r <= ST_DRAIN;
                            end else begin
                                state_r     <= ST_COMPUTE;
                                act_ready_r <= 1'b1;
                            end
                        end else begin
                            row_cnt_r <= row_cnt_r + RW'(1'b1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    // act_ready low here only for an empty job
                    if (!act_ready_r) begin
                        state_r <= ST_DRAIN;
                    end else if (act_acc_s) begin
                        acc_cnt_r <= acc_cnt_r + CNT_W'(1'b1);
                        if (acc_cnt_r + CNT_W'(1'b1) == num_vec_r) begin
                            act_ready_r <= 1'b0;
                            state_r     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tag_r == '0) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    w_ready_r   <= 1'b0;
                    act_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Capture accepted vectors (zero bubble otherwise) and track validity tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_r     <= '0;
            act_cap_r <= '0;
        end else begin
            tag_r     <= {tag_r[L-2:0], act_acc_s};
            act_cap_r <= act_acc_s ? bus.act_vec : '0;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_skew
        ws_skew_line #(.DEPTH(r), .W(D_W)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (act_cap_r[r]),
            .dout (arr_m0[r])
        );
    end

    // Column c leaves the array c cycles after column 0, so it is held N-c stages.
    for (genvar c = 0; c < N; c++) begin : g_deskew
        ws_skew_line #(.DEPTH(N - c), .W(2 * D_W)) u_deskew (
            .clk  (clk),
            .rst  (rst),
            .din  (arr_m2[c]),
            .dout (bus.res_vec[c])
        );
    end

    assign bus.w_ready   = w_ready_r;
    assign bus.act_ready = act_ready_r;
    assign bus.res_valid = tag_r[L-1];
    assign load_weight   = w_acc_s;
    assign arr_m1        = w_acc_s ? bus.w_row : '0;
    assign busy          = busy_r;
    assign done          = done_r;

`ifdef WS_PERF_CNT_EN
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_bubbles_r;

    // Busy-cycle and input-starvation counters, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_r  <= 32'd0;
            perf_bubbles_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            perf_cycles_r  <= 32'd0;
            perf_bubbles_r <= 32'd0;
        end else begin
            if (busy_r) begin
                perf_cycles_r <= perf_cycles_r + 32'd1;
            end
            if ((state_r == ST_COMPUTE) && act_ready_r && !bus.act_valid) begin
                perf_bubbles_r <= perf_bubbles_r + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_r;
    assign perf_bubbles = perf_bubbles_r;
`endif

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Scoreboard bench for ws_array_ctrl driving a behavioural systolic array model.
module tb_ws_array_ctrl;

    localparam int D_W   = 8;
    localparam int N     = 4;
    localparam int CNT_W = 16;
    localparam int PW    = 2 * D_W;
    localparam int LAT   = 2 * N + 1;

    typedef logic [N-1:0][D_W-1:0] vec_t;
    typedef logic [N-1:0][PW-1:0]  res_t;
    typedef struct {
        res_t        v;
        int unsigned cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start, skip_load, busy, done, load_weight;
    logic [CNT_W-1:0]     num_vec;
    logic [N-1:0][D_W-1:0] arr_m0, arr_m1;
    logic [N-1:0][PW-1:0]  arr_m2;
`ifdef WS_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_bubbles;
`endif

    ws_array_ctrl_if #(.D_W(D_W), .N(N)) bus ();

    ws_array_ctrl #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .skip_load   (skip_load),
        .num_vec     (num_vec),
        .busy        (busy),
        .done        (done),
        .bus         (bus),
        .load_weight (load_weight),
        .arr_m0      (arr_m0),
        .arr_m1      (arr_m1),
        .arr_m2      (arr_m2)
`ifdef WS_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_bubbles(perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural array: weights shift down on load_weight; act moves right, sums move down.
    logic [D_W-1:0] pe_w [N][N];
    logic [D_W-1:0] pe_a [N][N];
    logic [PW-1:0]  pe_s [N][N];

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                pe_a[r][c] <= (c == 0) ? arr_m0[r] : pe_a[r][(c == 0) ? 0 : c - 1];
                pe_s[r][c] <= ((r == 0) ? PW'(0) : pe_s[(r == 0) ? 0 : r - 1][c])
                              + PW'((c == 0) ? arr_m0[r] : pe_a[r][(c == 0) ? 0 : c - 1]) * PW'(pe_w[r][c]);
                if (load_weight) begin
                    pe_w[r][c] <= (r == 0) ? arr_m1[c] : pe_w[(r == 0) ? 0 : r - 1][c];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N; c++) arr_m2[c] = pe_s[N-1][c];
    end

    // Reference: weight matrix wm[row][col]; result col c = sum_r act[r]*wm[r][c] mod 2^PW.
    logic [D_W-1:0] wm [N][N];
    vec_t           vq[$];
    exp_t           exp_q[$];
    int             n_checks = 0;
    int             n_err = 0;
    int             lw_cnt = 0;
    int             done_cnt = 0;
    int             busy_cnt = 0;
    int unsigned    cyc = 0;

    function automatic res_t ref_mvm(input vec_t a);
        res_t o;
        for (int c = 0; c < N; c++) begin
            int unsigned acc;
            acc = 0;
            for (int r = 0; r < N; r++) acc = acc + a[r] * wm[r][c];
            o[c] = PW'(acc);
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever a result is presented.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_res_valid", 1, 0);
                end else begin
                    chk("res_vec", bus.res_vec, exp_q[0].v);
                    chk("res_latency", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
            if (load_weight) lw_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input bit skip, input int nv);
        lw_cnt    = 0;
        busy_cnt  = 0;
        start     = 1'b1;
        skip_load = skip;
        num_vec   = CNT_W'(nv);
        tick();
        start     = 1'b0;
        skip_load = 1'b0;
        num_vec   = '0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic load_rows(input bit gaps);
        int i;
        int guard;
        bit hole;
        i = 0; guard = 0; hole = 1'b0;
        while (i < N && guard < 200) begin
            if (gaps && hole) begin
                bus.w_valid = 1'b0;
            end else begin
                bus.w_valid = 1'b1;
                for (int c = 0; c < N; c++) bus.w_row[c] = wm[N-1-i][c];
                if (bus.w_ready) i++;
            end
            hole = !hole;
            tick();
            guard++;
        end
        bus.w_valid = 1'b0;
        bus.w_row   = '0;
        if (i < N) chk("load_timeout", i, N);
    endtask

    task automatic send_vecs(input int nv, input int gap, input bit rnd, input bit poke);
        for (int k = 0; k < nv; k++) begin
            int g;
            int guard;
            exp_t e;
            guard = 0;
            g = (k == 0) ? 0 : (rnd ? int'($urandom_range(gap, 0)) : gap);
            repeat (g) tick();
            bus.act_valid = 1'b1;
            bus.act_vec   = vq[k];
            if (poke && k == 0) begin
                start = 1'b1; num_vec = CNT_W'(7); skip_load = 1'b0;
            end
            while (!bus.act_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (bus.act_ready) begin
                e.v   = ref_mvm(vq[k]);
                e.cyc = cyc + LAT;
                exp_q.push_back(e);
            end else begin
                chk("act_ready_timeout", 0, 1);
            end
            tick();
            bus.act_valid = 1'b0;
            start = 1'b0; num_vec = '0;
        end
    endtask

    task automatic wait_done(input int exp_lw);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!done && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", done, 1);
        chk("results_drained", exp_q.size(), 0);
        chk("load_weight_cycles", lw_cnt, exp_lw);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
`ifdef WS_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, busy_cnt);
`endif
    endtask

    task automatic set_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wm[r][c] = (r == c) ? D_W'(1) : D_W'(0);
    endtask

    task automatic set_random_w();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) wm[r][c] = D_W'($urandom);
    endtask

    task automatic fill_random(input int n);
        vq.delete();
        for (int k = 0; k < n; k++) begin
            vec_t v;
            for (int r = 0; r < N; r++) v[r] = D_W'($urandom);
            vq.push_back(v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_w_ready"}, bus.w_ready, 0);
        chk({tag, "_act_ready"}, bus.act_ready, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_load_weight"}, load_weight, 0);
        chk({tag, "_arr_m0"}, arr_m0, 0);
        chk({tag, "_arr_m1"}, arr_m1, 0);
        chk({tag, "_res_vec"}, bus.res_vec, 0);
    endtask

    initial begin
        int dsnap;
        start = 1'b0; skip_load = 1'b0; num_vec = '0;
        bus.w_valid = 1'b0; bus.w_row = '0; bus.act_valid = 1'b0; bus.act_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Identity weights, single vector [1,2,3,4]
        set_identity();
        vq.delete();
        begin
            vec_t v;
            for (int r = 0; r < N; r++) v[r] = D_W'(r + 1);
            vq.push_back(v);
        end
        start_job(1'b0, 1); load_rows(1'b0); send_vecs(1, 0, 1'b0, 1'b0); wait_done(N);

        // Weights all 2, four back-to-back vectors [k,k,k,k]
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) wm[r][c] = D_W'(2);
        vq.delete();
        for (int k = 1; k <= 4; k++) begin
            vec_t v;
            for (int r = 0; r < N; r++) v[r] = D_W'(k);
            vq.push_back(v);
        end
        start_job(1'b0, 4); load_rows(1'b0); send_vecs(4, 0, 1'b0, 1'b0); wait_done(N);

        // Same weights through a gapped load
        start_job(1'b0, 4); load_rows(1'b1); send_vecs(4, 0, 1'b0, 1'b0); wait_done(N);

        // Identity load, then skip_load job with a start poke mid-job
        set_identity();
        start_job(1'b0, 1); load_rows(1'b0); send_vecs(1, 0, 1'b0, 1'b0); wait_done(N);
        fill_random(2);
        start_job(1'b1, 2); send_vecs(2, 0, 1'b0, 1'b1); wait_done(0);

        // Activation gaps of three cycles
        fill_random(3);
        start_job(1'b1, 3); send_vecs(3, 3, 1'b0, 1'b0); wait_done(0);
`ifdef WS_PERF_CNT_EN
        chk("perf_bubbles", perf_bubbles, 6);
`endif

        // Empty jobs
        start_job(1'b1, 0); wait_done(0);
        start_job(1'b0, 0); load_rows(1'b0); wait_done(N);

        // Randomised jobs
        for (int j = 0; j < 4; j++) begin
            int nv;
            bit skip;
            nv   = int'($urandom_range(12, 4));
            skip = (j > 0) && ($urandom_range(1, 0) == 1);
            fill_random(nv);
            start_job(skip, nv);
            if (!skip) begin
                set_random_w();
                load_rows($urandom_range(1, 0) == 1);
            end
            send_vecs(nv, 2, 1'b1, 1'b0);
            wait_done(skip ? 0 : N);
        end

        // Reset asserted mid-COMPUTE
        fill_random(10);
        start_job(1'b1, 10);
        send_vecs(3, 0, 1'b0, 1'b0);
        #3 rst = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        dsnap = done_cnt;
        tick(); tick();
        rst = 1'b1;
        repeat (20) tick();
        chk("no_done_after_reset", done_cnt, dsnap);
        chk("idle_after_reset", busy, 0);

        // Clean job after reset
        set_random_w();
        fill_random(3);
        start_job(1'b0, 3); load_rows(1'b0); send_vecs(3, 1, 1'b1, 1'b0); wait_done(N);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
